vpu_instruction_queue_mp: RTL and testbench

- Parametrised successor of the single-port vector instruction queue.
- Sits between the VPU decoder and the VPU dispatcher.
- Buffers decoded uOPs in order. Presents up to DISP_WIDTH oldest entries per cycle for in-order multi-issue.
- Supports arbitrary (non-power-of-2) depth, a synchronous flush, and occupancy/almost-full status.

---
 rtl/vpu_instruction_queue_mp_pkg.sv | 32 +++
 rtl/vpu_instruction_queue_mp_if.sv | 29 ++
 rtl/vpu_instruction_queue_mp_ptr_wrap.sv | 23 ++
 rtl/vpu_instruction_queue_mp.sv | 132 +++++++++++++
 tb/tb_vpu_instruction_queue_mp.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/vpu_instruction_queue_mp_pkg.sv
// Shared VPU types for the multi-port instruction queue: uOP format, functional-unit
// enum and the queue entry record.
package vpu_instruction_queue_mp_pkg;

   typedef enum logic [1:0] {
      VALU = 2'd0,
      VMUL = 2'd1,
      VLSU = 2'd2,
      VCFG = 2'd3
   } vpu_fu_e;

   typedef struct packed {
      vpu_fu_e    fu;
      logic [7:0] id;
      logic [4:0] vd;
      logic [4:0] vs1;
      logic [4:0] vs2;
   } VPU_uOP_t;

   localparam int VIQ_DEPTH = 8;

   typedef struct packed {
      logic     valid;
      VPU_uOP_t uop;
   } VIQ_ENTRY_t;

   // Config uOPs are consumed by the config path and never occupy a queue slot.
   function automatic logic is_vcfg(input VPU_uOP_t u);
      return u.fu == VCFG;
   endfunction

endpackage

// File: rtl/vpu_instruction_queue_mp_if.sv
// Decode/dispatch handshake bundle of the instruction queue; the queue takes the
// slave modport, decoder/dispatcher side (or a bench) takes the master modport.
interface vpu_instruction_queue_mp_if #(
   parameter int DISP_WIDTH = 2,
   parameter int CNT_W      = 4
);
   import vpu_instruction_queue_mp_pkg::*;

   logic                            flush_i;
   logic                            decode_entry_valid_i;
   VPU_uOP_t                        decode_entry_i;
   logic                            decode_accept_o;
   logic     [DISP_WIDTH-1:0]       dispatch_valid_o;
   VPU_uOP_t [DISP_WIDTH-1:0]       dispatch_entry_o;
   logic     [DISP_WIDTH-1:0]       dispatch_ack_i;
   logic     [CNT_W-1:0]            count_o;
   logic                            almost_full_o;

   modport slave (
      input  flush_i, decode_entry_valid_i, decode_entry_i, dispatch_ack_i,
      output decode_accept_o, dispatch_valid_o, dispatch_entry_o, count_o, almost_full_o
   );

   modport master (
      output flush_i, decode_entry_valid_i, decode_entry_i, dispatch_ack_i,
      input  decode_accept_o, dispatch_valid_o, dispatch_entry_o, count_o, almost_full_o
   );

endinterface

// File: rtl/vpu_instruction_queue_mp_ptr_wrap.sv
// Modulo-DEPTH pointer advance by a small increment (0..DISP_WIDTH); works for
// non-power-of-2 depths because the increment never exceeds DEPTH.
module vpu_viq_ptr_wrap #(
   parameter int DEPTH = 8,
   parameter int INC_W = 2,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic [PTR_W-1:0] ptr_i,
   input  logic [INC_W-1:0] inc_i,
   output logic [PTR_W-1:0] ptr_o
);
   localparam int SUM_W = PTR_W + 1;

   logic [SUM_W-1:0] sum;
   logic [SUM_W-1:0] wrapped;

   always_comb begin
      sum     = {1'b0, ptr_i} + SUM_W'(inc_i);
      wrapped = (sum >= SUM_W'(DEPTH)) ? (sum - SUM_W'(DEPTH)) : sum;
      ptr_o   = wrapped[PTR_W-1:0];
   end

endmodule

// File: rtl/vpu_instruction_queue_mp.sv
// In-order uOP queue presenting up to DISP_WIDTH oldest entries per cycle.
// Optional zero-latency empty-queue bypass under `define VPU_VIQ_BYPASS_EN.
module vpu_instruction_queue_mp
   import vpu_instruction_queue_mp_pkg::*;
#(
   parameter int DEPTH      = VIQ_DEPTH,
   parameter int DISP_WIDTH = 2,
   parameter int AFULL_TH   = 2
) (
   input logic                          clk_i,
   input logic                          rst_ni,
   vpu_instruction_queue_mp_if.slave    viq
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int POP_W = $clog2(DISP_WIDTH + 1);

   logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
   logic [PTR_W-1:0]      head_inc, tail_inc;
   logic [CNT_W-1:0]      count_q, count_d;
   VIQ_ENTRY_t            entries_q [DEPTH];
   VIQ_ENTRY_t            entries_d [DEPTH];
   logic [PTR_W-1:0]      slot_idx [DISP_WIDTH];
   logic [DISP_WIDTH-1:0] queued_valid;
   logic [POP_W-1:0]      pops;
   logic                  ack_run;
   logic                  vcfg_uop;
   logic                  push_req;
   logic                  push;
`ifdef VPU_VIQ_BYPASS_EN
   logic                  bypass_hit;
   logic                  bypass_take;
`endif

   vpu_viq_ptr_wrap #(.DEPTH(DEPTH), .INC_W(POP_W)) u_head_wrap (
      .ptr_i (head_q), .inc_i (pops), .ptr_o (head_inc)
   );

   vpu_viq_ptr_wrap #(.DEPTH(DEPTH), .INC_W(POP_W)) u_tail_wrap (
      .ptr_i (tail_q), .inc_i (POP_W'(push)), .ptr_o (tail_inc)
   );

   for (genvar gi = 0; gi < DISP_WIDTH; gi++) begin : gen_slot
      vpu_viq_ptr_wrap #(.DEPTH(DEPTH), .INC_W(POP_W)) u_slot_wrap (
         .ptr_i (head_q), .inc_i (POP_W'(gi)), .ptr_o (slot_idx[gi])
      );
      assign queued_valid[gi] = (count_q > CNT_W'(gi)) & entries_q[slot_idx[gi]].valid;
   end

   // Only the thermometer prefix of acks on queued entries counts as pops.
   always_comb begin
      pops    = '0;
      ack_run = 1'b1;
      for (int k = 0; k < DISP_WIDTH; k++) begin
         ack_run = ack_run & viq.dispatch_ack_i[k] & queued_valid[k];
         pops    = pops + POP_W'(ack_run);
      end
   end

   always_comb begin
      vcfg_uop = is_vcfg(viq.decode_entry_i);
      push_req = viq.decode_entry_valid_i & ~viq.flush_i & ~vcfg_uop;
`ifdef VPU_VIQ_BYPASS_EN
      bypass_hit  = push_req & (count_q == '0);
      bypass_take = bypass_hit & viq.dispatch_ack_i[0];
      push        = push_req & (count_q < CNT_W'(DEPTH)) & ~bypass_take;
      viq.decode_accept_o = rst_ni & (vcfg_uop ? (viq.decode_entry_valid_i & ~viq.flush_i)
                                               : (push | bypass_take));
`else
      push = push_req & (count_q < CNT_W'(DEPTH));
      viq.decode_accept_o = rst_ni & (vcfg_uop ? (viq.decode_entry_valid_i & ~viq.flush_i)
                                               : push);
`endif
   end

   always_comb begin
      head_d    = head_inc;
      tail_d    = tail_inc;
      count_d   = count_q + CNT_W'(push) - CNT_W'(pops);
      entries_d = entries_q;
      for (int k = 0; k < DISP_WIDTH; k++) begin
         if (POP_W'(k) < pops) entries_d[slot_idx[k]].valid = 1'b0;
      end
      if (push) begin
         entries_d[tail_q].valid = 1'b1;
         entries_d[tail_q].uop   = viq.decode_entry_i;
      end
      if (viq.flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         for (int i = 0; i < DEPTH; i++) entries_d[i].valid = 1'b0;
      end
   end

   // Payloads are deliberately left out of reset; only the valid bits matter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) entries_q[i].valid <= 1'b0;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         entries_q <= entries_d;
      end
   end

   always_comb begin
      for (int k = 0; k < DISP_WIDTH; k++) begin
         viq.dispatch_valid_o[k] = rst_ni & queued_valid[k];
         viq.dispatch_entry_o[k] = entries_q[slot_idx[k]].uop;
      end
`ifdef VPU_VIQ_BYPASS_EN
      if (bypass_hit) begin
         viq.dispatch_valid_o[0] = rst_ni;
         viq.dispatch_entry_o[0] = viq.decode_entry_i;
      end
`endif
   end

   assign viq.count_o       = count_q;
   assign viq.almost_full_o = (int'(DEPTH) - int'(count_q)) <= AFULL_TH;

   if (DISP_WIDTH > 1) begin : gen_thermo_chk
      ack_thermometer: assert property (@(posedge clk_i) disable iff (!rst_ni)
         viq.dispatch_ack_i[1] |-> viq.dispatch_ack_i[0]);
   end

endmodule

// File: tb/tb_vpu_instruction_queue_mp.sv
// Directed bench for vpu_instruction_queue_mp at DEPTH=6, DISP_WIDTH=2, AFULL_TH=2.
module tb_vpu_instruction_queue_mp;
   import vpu_instruction_queue_mp_pkg::*;

   localparam int DEPTH      = 6;
   localparam int DISP_WIDTH = 2;
   localparam int AFULL_TH   = 2;
   localparam int CNT_W      = $clog2(DEPTH + 1);

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   model_q[$];

   vpu_instruction_queue_mp_if #(.DISP_WIDTH(DISP_WIDTH), .CNT_W(CNT_W)) viq ();

   vpu_instruction_queue_mp #(
      .DEPTH(DEPTH), .DISP_WIDTH(DISP_WIDTH), .AFULL_TH(AFULL_TH)
   ) u_dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .viq    (viq)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input vpu_fu_e fu, input int id,
                        input logic [1:0] ack, input logic fl);
      logic [7:0] id8;
      id8 = id[7:0];
      viq.decode_entry_valid_i = v;
      viq.decode_entry_i       = '{fu: fu, id: id8, vd: 5'd1, vs1: 5'd2, vs2: 5'd3};
      viq.dispatch_ack_i       = ack;
      viq.flush_i              = fl;
      #1;
   endtask

   initial begin
      drive(1'b1, VALU, 0, 2'b00, 1'b0);
      chk("rst_accept", 32'(viq.decode_accept_o), 0);
      chk("rst_valid", 32'(viq.dispatch_valid_o), 0);
      chk("rst_count", 32'(viq.count_o), 0);
      chk("rst_afull", 32'(viq.almost_full_o), 0);
      $display("reset: accept=%0d count=%0d", viq.decode_accept_o, viq.count_o);
      @(posedge clk_i);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      drive(1'b0, VALU, 0, 2'b00, 1'b0);

      for (int i = 1; i <= 6; i++) begin
         drive(1'b1, VALU, i, 2'b00, 1'b0);
`ifndef VPU_VIQ_BYPASS_EN
         if (i == 1) chk("no_same_cycle_dispatch", 32'(viq.dispatch_valid_o), 0);
`endif
         chk("fill_accept", 32'(viq.decode_accept_o), 1);
         tick();
         model_q.push_back(i);
         chk("fill_count", 32'(viq.count_o), 32'(i));
         chk("fill_afull", 32'(viq.almost_full_o), (i >= 4) ? 1 : 0);
         $display("push id=%0d count=%0d afull=%0d", i, viq.count_o, viq.almost_full_o);
      end

      drive(1'b1, VALU, 7, 2'b00, 1'b0);
      chk("full_refuse", 32'(viq.decode_accept_o), 0);
      chk("full_valid", 32'(viq.dispatch_valid_o), 32'h3);
      chk("full_slot0", 32'(viq.dispatch_entry_o[0].id), 1);
      chk("full_slot1", 32'(viq.dispatch_entry_o[1].id), 2);

      drive(1'b1, VALU, 7, 2'b11, 1'b0);
      chk("full_pop_refuse", 32'(viq.decode_accept_o), 0);
      tick();
      void'(model_q.pop_front());
      void'(model_q.pop_front());
      chk("after_pop2_count", 32'(viq.count_o), 4);
      chk("after_pop2_slot0", 32'(viq.dispatch_entry_o[0].id), 3);
      chk("after_pop2_slot1", 32'(viq.dispatch_entry_o[1].id), 4);
      $display("full pop2: count=%0d slot0=%0d", viq.count_o, viq.dispatch_entry_o[0].id);

      drive(1'b1, VALU, 7, 2'b00, 1'b0);
      chk("freed_accept", 32'(viq.decode_accept_o), 1);
      tick();
      model_q.push_back(7);
      chk("freed_count", 32'(viq.count_o), 5);
      chk("freed_afull", 32'(viq.almost_full_o), 1);

      drive(1'b0, VALU, 0, 2'b11, 1'b0);
      tick();
      void'(model_q.pop_front());
      void'(model_q.pop_front());
      chk("pre_vcfg_count", 32'(viq.count_o), 3);

      drive(1'b1, VCFG, 99, 2'b00, 1'b0);
      chk("vcfg_accept", 32'(viq.decode_accept_o), 1);
      tick();
      chk("vcfg_count", 32'(viq.count_o), 3);
      chk("vcfg_slot0", 32'(viq.dispatch_entry_o[0].id), 5);
      chk("vcfg_slot1", 32'(viq.dispatch_entry_o[1].id), 6);
      $display("vcfg: count=%0d", viq.count_o);

      for (int c = 0; c < 20; c++) begin
         drive(1'b1, VALU, 8 + c, 2'b01, 1'b0);
         chk("wrap_slot0", 32'(viq.dispatch_entry_o[0].id), 32'(model_q[0]));
         chk("wrap_slot1", 32'(viq.dispatch_entry_o[1].id), 32'(model_q[1]));
         chk("wrap_accept", 32'(viq.decode_accept_o), 1);
         $display("wrap c=%0d slot0=%0d push=%0d", c, viq.dispatch_entry_o[0].id, 8 + c);
         tick();
         void'(model_q.pop_front());
         model_q.push_back(8 + c);
      end
      chk("wrap_count", 32'(viq.count_o), 3);
      chk("wrap_last_slot0", 32'(viq.dispatch_entry_o[0].id), 25);

      drive(1'b1, VALU, 28, 2'b00, 1'b0);
      tick();
      drive(1'b1, VALU, 29, 2'b00, 1'b0);
      tick();
      chk("pre_flush_count", 32'(viq.count_o), 5);

      drive(1'b1, VALU, 30, 2'b11, 1'b1);
      chk("flush_accept", 32'(viq.decode_accept_o), 0);
      tick();
      model_q.delete();
      drive(1'b0, VALU, 0, 2'b00, 1'b0);
      chk("flush_count", 32'(viq.count_o), 0);
      chk("flush_valid", 32'(viq.dispatch_valid_o), 0);
      chk("flush_afull", 32'(viq.almost_full_o), 0);
      $display("flush: count=%0d valid=%0b", viq.count_o, viq.dispatch_valid_o);

      drive(1'b1, VALU, 31, 2'b00, 1'b0);
      tick();
      chk("post_flush_count", 32'(viq.count_o), 1);
      chk("post_flush_slot0", 32'(viq.dispatch_entry_o[0].id), 31);
      chk("post_flush_valid", 32'(viq.dispatch_valid_o), 32'h1);

      drive(1'b1, VALU, 32, 2'b01, 1'b0);
      chk("one_pushpop_accept", 32'(viq.decode_accept_o), 1);
      tick();
      chk("one_pushpop_count", 32'(viq.count_o), 1);
      chk("one_pushpop_slot0", 32'(viq.dispatch_entry_o[0].id), 32);
      $display("count1 push+pop: slot0=%0d", viq.dispatch_entry_o[0].id);

      for (int i = 33; i <= 35; i++) begin
         drive(1'b1, VALU, i, 2'b00, 1'b0);
         tick();
      end
      chk("pre_rst_count", 32'(viq.count_o), 4);
      chk("pre_rst_afull", 32'(viq.almost_full_o), 1);

      drive(1'b1, VALU, 36, 2'b00, 1'b0);
      #2 rst_ni = 1'b0;
      #1;
      chk("midrst_count", 32'(viq.count_o), 0);
      chk("midrst_valid", 32'(viq.dispatch_valid_o), 0);
      chk("midrst_afull", 32'(viq.almost_full_o), 0);
      chk("midrst_accept", 32'(viq.decode_accept_o), 0);
      $display("mid-cycle reset: count=%0d", viq.count_o);
      tick();
      tick();
      rst_ni = 1'b1;
      drive(1'b0, VALU, 0, 2'b00, 1'b0);
      chk("post_rst_count", 32'(viq.count_o), 0);

      drive(1'b1, VALU, 50, 2'b01, 1'b0);
`ifdef VPU_VIQ_BYPASS_EN
      chk("bypass_valid", 32'(viq.dispatch_valid_o), 32'h1);
      chk("bypass_slot0", 32'(viq.dispatch_entry_o[0].id), 50);
      chk("bypass_accept", 32'(viq.decode_accept_o), 1);
      tick();
      chk("bypass_count", 32'(viq.count_o), 0);
`else
      chk("empty_ack_valid", 32'(viq.dispatch_valid_o), 0);
      chk("empty_ack_accept", 32'(viq.decode_accept_o), 1);
      tick();
      chk("empty_ack_count", 32'(viq.count_o), 1);
      chk("empty_ack_slot0", 32'(viq.dispatch_entry_o[0].id), 50);
`endif
      $display("empty push with ack0: count=%0d", viq.count_o);
      drive(1'b0, VALU, 0, 2'b00, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
